conv_sequencer: RTL and testbench



---
 rtl/conv_sequencer_if.sv | 33 +++
 rtl/conv_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// Image-RAM read port and result handshake shared by conv_sequencer (master)
// and the RAM/result consumer (slave).
interface conv_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 4,
    parameter int EXP_SIZE   = 5,
    parameter int MANT_SIZE  = 10
);
    logic                   img_rd_en;
    logic [2*ADDR_SIZE-1:0] img_addr;
    logic [DATA_WIDTH-1:0]  img_rd_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [EXP_SIZE:0]      res_exp;
    logic [2*MANT_SIZE:0]   res_sum;
    logic [ADDR_SIZE-1:0]   res_row;
    logic [ADDR_SIZE-1:0]   res_col;
    logic                   res_last;

    modport master (
        output img_rd_en, img_addr,
        input  img_rd_data,
        output res_valid, res_exp, res_sum, res_row, res_col, res_last,
        input  res_ready
    );

    modport slave (
        input  img_rd_en, img_addr,
        output img_rd_data,
        input  res_valid, res_exp, res_sum, res_row, res_col, res_last,
        output res_ready
    );
endinterface

// File: rtl/conv_sequencer.sv
// Frame controller for the 3x3 BFP convolution: holds weights, walks a stride-1
// window over the image RAM with a sliding-column fetch, and registers results.
module conv_sequencer #(
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int EXP_SIZE    = 5,
    parameter int MANT_SIZE   = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_SIZE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  ker_wr_en,
    input  logic [3:0]            ker_wr_idx,
    input  logic [DATA_WIDTH-1:0] ker_wr_data,
    conv_sequencer_if.master      bus,
    output logic [DATA_WIDTH-1:0] ImgP1, ImgP2, ImgP3, ImgP4, ImgP5, ImgP6, ImgP7, ImgP8, ImgP9,
    output logic [DATA_WIDTH-1:0] KerW1, KerW2, KerW3, KerW4, KerW5, KerW6, KerW7, KerW8, KerW9,
    input  logic [EXP_SIZE:0]     cb_exp,
    input  logic [2*MANT_SIZE:0]  cb_sum
);
    localparam int                   N_WIN    = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(N_WIN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [2:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]   r_q, r_d, c_q, c_d;
    word_t                  win_q [9];
    word_t                  win_d [9];
    word_t                  ker_q [9];
    word_t                  ker_d [9];
    word_t                  stage0_q, stage0_d, stage1_q, stage1_d;
    logic [2*ADDR_SIZE-1:0] addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   res_valid_q, res_valid_d;
    logic [EXP_SIZE:0]      res_exp_q, res_exp_d;
    logic [2*MANT_SIZE:0]   res_sum_q, res_sum_d;
    logic [ADDR_SIZE-1:0]   res_row_q, res_row_d, res_col_q, res_col_d;
    logic                   res_last_q, res_last_d;

    logic                   rd_en;
    logic [ADDR_SIZE-1:0]   rd_row, rd_col;
    logic                   capture, res_hs;

    // Row/column offset of FILL step k inside the 3x3 window (row-major).
    function automatic logic [1:0] ofs_row(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: ofs_row = 2'd0;
            4'd3, 4'd4, 4'd5: ofs_row = 2'd1;
            default:          ofs_row = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] ofs_col(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: ofs_col = 2'd0;
            4'd1, 4'd4, 4'd7: ofs_col = 2'd1;
            default:          ofs_col = 2'd2;
        endcase
    endfunction

    assign capture = (state_q == S_WAIT) && (!res_valid_q || bus.res_ready);
    assign res_hs  = res_valid_q && bus.res_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        win_d       = win_q;
        ker_d       = ker_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_exp_d   = res_exp_q;
        res_sum_d   = res_sum_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        res_last_d  = res_last_q;
        rd_en       = 1'b0;
        rd_row      = r_q;
        rd_col      = c_q;

        if (state_q == S_IDLE && ker_wr_en) begin
            for (int k = 0; k < 9; k++) begin
                if (ker_wr_idx == 4'(k)) ker_d[k] = ker_wr_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    cnt_d   = 4'd0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            S_FILL: begin
                if (cnt_q < 4'd9) begin
                    rd_en  = 1'b1;
                    rd_row = r_q + ADDR_SIZE'(ofs_row(cnt_q));
                    rd_col = c_q + ADDR_SIZE'(ofs_col(cnt_q));
                end
                // Read data lands one cycle after its strobe, hence slot cnt-1.
                for (int k = 0; k < 9; k++) begin
                    if (cnt_q == 4'(k + 1)) win_d[k] = bus.img_rd_data;
                end
                if (cnt_q == 4'd9) begin
                    state_d = S_ISSUE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    if (c_q < LAST_IDX) begin
                        c_d     = c_q + ADDR_SIZE'(1);
                        state_d = S_SHIFT;
                        cnt_d   = 4'd0;
                    end else if (r_q < LAST_IDX) begin
                        r_d     = r_q + ADDR_SIZE'(1);
                        c_d     = '0;
                        state_d = S_FILL;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q < 4'd3) begin
                    rd_en  = 1'b1;
                    rd_row = r_q + ADDR_SIZE'(cnt_q);
                    rd_col = c_q + ADDR_SIZE'(2);
                end
                if (cnt_q == 4'd1) stage0_d = bus.img_rd_data;
                if (cnt_q == 4'd2) stage1_d = bus.img_rd_data;
                // The bottom pixel of the new column arrives in the shift cycle itself.
                if (cnt_q == 4'd3) begin
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    win_d[2] = stage0_q;
                    win_d[3] = win_q[4];
                    win_d[4] = win_q[5];
                    win_d[5] = stage1_q;
                    win_d[6] = win_q[7];
                    win_d[7] = win_q[8];
                    win_d[8] = bus.img_rd_data;
                    state_d  = S_ISSUE;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (res_hs && res_last_q) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A capture in the same cycle as a handshake reloads the slot.
        if (capture) begin
            res_valid_d = 1'b1;
            res_exp_d   = cb_exp;
            res_sum_d   = cb_sum;
            res_row_d   = r_q;
            res_col_d   = c_q;
            res_last_d  = (r_q == LAST_IDX) && (c_q == LAST_IDX);
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end

        if (rd_en) addr_d = {rd_row, rd_col};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            r_q         <= '0;
            c_q         <= '0;
            // NOTE: window and weight arrays are reset too, because they drive ports that must read 0 out of reset.
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
                ker_q[k] <= '0;
            end
            stage0_q    <= '0;
            stage1_q    <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_exp_q   <= '0;
            res_sum_q   <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            res_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            win_q       <= win_d;
            ker_q       <= ker_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_exp_q   <= res_exp_d;
            res_sum_q   <= res_sum_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            res_last_q  <= res_last_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign bus.img_rd_en = rd_en;
    assign bus.img_addr  = rd_en ? {rd_row, rd_col} : addr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_exp   = res_exp_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_row   = res_row_q;
    assign bus.res_col   = res_col_q;
    assign bus.res_last  = res_last_q;

    assign ImgP1 = win_q[0];
    assign ImgP2 = win_q[1];
    assign ImgP3 = win_q[2];
    assign ImgP4 = win_q[3];
    assign ImgP5 = win_q[4];
    assign ImgP6 = win_q[5];
    assign ImgP7 = win_q[6];
    assign ImgP8 = win_q[7];
    assign ImgP9 = win_q[8];
    assign KerW1 = ker_q[0];
    assign KerW2 = ker_q[1];
    assign KerW3 = ker_q[2];
    assign KerW4 = ker_q[3];
    assign KerW5 = ker_q[4];
    assign KerW6 = ker_q[5];
    assign KerW7 = ker_q[6];
    assign KerW8 = ker_q[7];
    assign KerW9 = ker_q[8];
endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: RAM and convolution-block models,
// a window-level scoreboard, and directed frame/backpressure/reset scenarios.
module tb_conv_sequencer;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int EW   = 5;
    localparam int MW   = 10;
    localparam int IMG  = 16;
    localparam int NW   = 14;
    localparam int NRES = NW * NW;
    localparam int NRD  = NW * (9 + (NW - 1) * 3);

    typedef logic [DW-1:0] win_t [9];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          ker_wr_en = 1'b0;
    logic [3:0]    ker_wr_idx = 4'd0;
    logic [DW-1:0] ker_wr_data = '0;
    win_t          imgp, kerw, ker_m;
    logic [EW:0]   cb_exp = '0;
    logic [2*MW:0] cb_sum = '0;
    logic [DW-1:0] image [IMG*IMG];
    int            exp_addr [NRD];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int rd_idx = 0, res_idx = 0, done_cnt = 0, busy_cycles = 0;
    int first_valid = -1, done_at = -1;
    int first_addr [12];
    int row2_addr [3];
    int mon_r, mon_c;
    win_t mon_w, chk_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv_sequencer_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .EXP_SIZE(EW), .MANT_SIZE(MW)) bus ();

    conv_sequencer #(
        .IMAGE_SIZE(IMG), .KERNEL_SIZE(3), .EXP_SIZE(EW), .MANT_SIZE(MW), .DATA_WIDTH(DW), .ADDR_SIZE(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ker_wr_en(ker_wr_en), .ker_wr_idx(ker_wr_idx), .ker_wr_data(ker_wr_data),
        .bus(bus),
        .ImgP1(imgp[0]), .ImgP2(imgp[1]), .ImgP3(imgp[2]), .ImgP4(imgp[3]), .ImgP5(imgp[4]),
        .ImgP6(imgp[5]), .ImgP7(imgp[6]), .ImgP8(imgp[7]), .ImgP9(imgp[8]),
        .KerW1(kerw[0]), .KerW2(kerw[1]), .KerW3(kerw[2]), .KerW4(kerw[3]), .KerW5(kerw[4]),
        .KerW6(kerw[5]), .KerW7(kerw[6]), .KerW8(kerw[7]), .KerW9(kerw[8]),
        .cb_exp(cb_exp), .cb_sum(cb_sum)
    );

    // Toy convolution: any function of window and weights exposes a wrong pixel or weight.
    function automatic logic [2*MW:0] conv_sum(input win_t p, input win_t w);
        logic [2*MW:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) acc = acc + 21'(32'(p[k] ^ w[k]) * (k + 1));
        return acc;
    endfunction

    function automatic logic [EW:0] conv_exp(input win_t p);
        logic [EW:0] x;
        x = '0;
        for (int k = 0; k < 9; k++) x = x ^ p[k][EW:0] ^ 6'(k);
        return x;
    endfunction

    function automatic win_t img_win(input int r, input int c);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) w[i*3+j] = image[(r+i)*IMG + c + j];
        return w;
    endfunction

    // Single-port RAM with one-cycle read latency, and the registered convolution block.
    always @(posedge clk) begin
        if (bus.img_rd_en) bus.img_rd_data <= image[bus.img_addr];
        cb_sum <= conv_sum(imgp, kerw);
        cb_exp <= conv_exp(imgp);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    // Scoreboard: read addresses and accepted results against the window-walk model.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.img_rd_en) begin
                if (rd_idx < NRD) check("img_addr", 32'(bus.img_addr), 32'(exp_addr[rd_idx]));
                else check("extra_read", 32'd1, 32'd0);
                if (rd_idx < 12) first_addr[rd_idx] = int'(bus.img_addr);
                if (rd_idx >= 48 && rd_idx < 51) row2_addr[rd_idx-48] = int'(bus.img_addr);
                rd_idx++;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (res_idx < NRES) begin
                    mon_r = res_idx / NW;
                    mon_c = res_idx % NW;
                    mon_w = img_win(mon_r, mon_c);
                    check("res_row", 32'(bus.res_row), 32'(mon_r));
                    check("res_col", 32'(bus.res_col), 32'(mon_c));
                    check("res_last", 32'(bus.res_last), 32'(res_idx == NRES - 1));
                    check("res_exp", 32'(bus.res_exp), 32'(conv_exp(mon_w)));
                    check("res_sum", 32'(bus.res_sum), 32'(conv_sum(mon_w, ker_m)));
                end else begin
                    check("extra_result", 32'd1, 32'd0);
                end
                res_idx++;
            end
            if (bus.res_valid && first_valid < 0) first_valid = cyc - start_cyc;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc - start_cyc;
            end
            if (busy) busy_cycles++;
        end
    end

    function automatic logic any_output_set();
        logic nz;
        nz = busy | done | bus.img_rd_en | (|bus.img_addr) | bus.res_valid | (|bus.res_exp) |
             (|bus.res_sum) | (|bus.res_row) | (|bus.res_col) | bus.res_last;
        for (int k = 0; k < 9; k++) nz = nz | (|imgp[k]) | (|kerw[k]);
        return nz;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 bus.res_ready = v;
    endtask

    task automatic write_ker(input int idx, input logic [DW-1:0] val);
        ker_wr_en   = 1'b1;
        ker_wr_idx  = 4'(idx);
        ker_wr_data = val;
        @(negedge clk);
        ker_wr_en   = 1'b0;
    endtask

    task automatic load_weights();
        for (int k = 0; k < 9; k++) begin
            write_ker(k, 16'h3C00 + 16'(k));
            ker_m[k] = 16'h3C00 + 16'(k);
        end
    endtask

    task automatic start_frame();
        rd_idx = 0; res_idx = 0; done_cnt = 0; busy_cycles = 0;
        first_valid = -1; done_at = -1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        tick(4);
    endtask

    task automatic check_frame_totals();
        check("result_count", 32'(res_idx), 32'(NRES));
        check("read_count", 32'(rd_idx), 32'(NRD));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        bus.res_ready = 1'b1;
        for (int a = 0; a < IMG*IMG; a++) image[a] = 16'($urandom);
        // Expected read order: full 3x3 fill per row, then one new column per step right.
        k = 0;
        for (int r = 0; r < NW; r++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin exp_addr[k] = (r+i)*IMG + j; k++; end
            for (int c = 1; c < NW; c++)
                for (int i = 0; i < 3; i++) begin exp_addr[k] = (r+i)*IMG + c + 2; k++; end
        end

        // Reset with start held high.
        start = 1'b1;
        tick(3);
        check("reset_outputs_zero", 32'(any_output_set()), 32'd0);
        rst = 1'b1;
        start = 1'b0;
        busy_cycles = 0;
        tick(10);
        check("idle_after_reset", 32'(busy_cycles), 32'd0);

        // Weight load, plus an out-of-range index that must be dropped.
        load_weights();
        write_ker(9, 16'hFFFF);
        tick(1);
        for (int i = 0; i < 9; i++) check("kerw_load", 32'(kerw[i]), 32'h3C00 + 32'(i));

        // Frame 1: no backpressure, timing pinned to literal cycle numbers.
        start_frame();
        wait_done(3000);
        check_frame_totals();
        check("first_res_valid_cycle", 32'(first_valid), 32'd13);
        check("done_cycle", 32'(done_at), 32'd1262);
        check("busy_cycles", 32'(busy_cycles), 32'd1262);
        check("addr0", 32'(first_addr[0]), 32'd0);
        check("addr2", 32'(first_addr[2]), 32'd2);
        check("addr3", 32'(first_addr[3]), 32'd16);
        check("addr5", 32'(first_addr[5]), 32'd18);
        check("addr6", 32'(first_addr[6]), 32'd32);
        check("addr8", 32'(first_addr[8]), 32'd34);
        check("shift_addr0", 32'(first_addr[9]), 32'd3);
        check("shift_addr1", 32'(first_addr[10]), 32'd19);
        check("shift_addr2", 32'(first_addr[11]), 32'd35);
        check("row2_fill0", 32'(row2_addr[0]), 32'd16);
        check("row2_fill1", 32'(row2_addr[1]), 32'd17);
        check("row2_fill2", 32'(row2_addr[2]), 32'd18);

        // Frame 2: start and a weight write while busy, then a 20-cycle stall at result 5.
        start_frame();
        tick(20);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        write_ker(4, 16'hBEEF);
        k = 0;
        while (res_idx < 5 && k < 500) begin @(negedge clk); k++; end
        check("reached_result5", 32'(res_idx >= 5), 32'd1);
        set_ready(1'b0);
        chk_w = img_win(0, 6);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (t == 12 || t == 19)
                for (int i = 0; i < 9; i++) check("imgp_stall", 32'(imgp[i]), 32'(chk_w[i]));
            if (t == 19) begin
                check("stall_res_valid", 32'(bus.res_valid), 32'd1);
                check("stall_res_col", 32'(bus.res_col), 32'd5);
                check("stall_res_count", 32'(res_idx), 32'd5);
            end
        end
        set_ready(1'b1);
        wait_done(3000);
        check_frame_totals();
        check("kerw5_busy_write", 32'(kerw[4]), 32'h3C04);
        tick(10);
        check("start_while_busy_ignored", 32'(busy), 32'd0);

        // Frame 3: reset at cycle 500 aborts with no done pulse.
        start_frame();
        k = 0;
        while ((cyc - start_cyc) < 500 && k < 1000) begin @(negedge clk); k++; end
        rst = 1'b0;
        @(negedge clk);
        check("midreset_outputs_zero", 32'(any_output_set()), 32'd0);
        rst = 1'b1;
        tick(20);
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        check("midreset_idle", 32'(busy), 32'd0);

        // Frame 4: restart after reloading the cleared weights.
        load_weights();
        start_frame();
        wait_done(3000);
        check_frame_totals();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
